// File: rtl/bram_bridge_pkg.sv
// Shared types and helpers for the CPU-bus-to-BRAM bridge.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bram_bridge_pkg;

  // Bridge control states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_HOLD = 2'd2,
    WR_DONE = 2'd3
  } state_t;

  // The read-latency counter is sized for the largest legal latency (4),
  // so one width serves every instance regardless of its P_RD_LAT.
  localparam int MAX_RD_LAT = 4;
  localparam int CNT_W      = $clog2(MAX_RD_LAT + 1);

  // True when addr falls in the half-open window [base, base+size)
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr >= base) && (addr < base + size);
  endfunction

endpackage

// File: rtl/bram_bridge_strobe_edge.sv
// Turns active-low CPU strobes into single-cycle "new assertion" pulses; write beats read.
// Latency: combinational pulse in the first cycle a strobe is seen low after being high.
// Backpressure: none; a strobe held low produces exactly one pulse.
module bram_bridge_strobe_edge (
  input  logic clk,
  input  logic reset,
  input  logic we_l,
  input  logic re_l,
  output logic new_we,
  output logic new_re
);

  logic prev_we_l;
  logic prev_re_l;

  // Remember strobe levels from the previous edge; reset to deasserted so a
  // strobe held low through reset registers as a fresh assertion.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_we_l <= 1'b1;
      prev_re_l <= 1'b1;
    end else begin
      prev_we_l <= we_l;
      prev_re_l <= re_l;
    end
  end

  assign new_we = ~we_l & prev_we_l;
  // A read is suppressed whenever the write strobe is also low
  assign new_re = ~re_l & prev_re_l & we_l;

endmodule

// File: rtl/bram_bus_bridge.sv
// Decodes a CPU address window and issues one registered BRAM access per strobe assertion.
// Latency: BRAM EN one clock after a new strobe; read data held after P_RD_LAT+1 clocks.
// Backpressure: O_WAIT stalls the CPU on reads until data is held; writes never stall.
// Optional write protect: define BRAM_BRIDGE_WP_EN to add I_WP / O_WP_ERR.
module bram_bus_bridge
  import bram_bridge_pkg::*;
#(
  parameter int unsigned P_ADDR_W      = 16,
  parameter int unsigned P_DATA_W      = 8,
  parameter int unsigned P_BRAM_ADDR_W = 13,
  parameter int unsigned P_BASE        = 32'h0000_C000,
  parameter int unsigned P_SIZE        = 32'h0000_2000,
  parameter int unsigned P_RD_LAT      = 1
) (
  input  logic                     I_CLK,
  input  logic                     I_RESET,
  input  logic [P_ADDR_W-1:0]      I_ADDR,
  inout  wire  [P_DATA_W-1:0]      IO_DATA,
  input  logic                     I_WE_L,
  input  logic                     I_RE_L,
  output logic                     O_WAIT,
  output logic                     O_SEL,
  output logic                     O_BRAM_EN,
  output logic                     O_BRAM_WE,
  output logic [P_BRAM_ADDR_W-1:0] O_BRAM_ADDR,
  output logic [P_DATA_W-1:0]      O_BRAM_DIN,
  input  logic [P_DATA_W-1:0]      I_BRAM_DOUT
`ifdef BRAM_BRIDGE_WP_EN
  ,
  input  logic                     I_WP,
  output logic                     O_WP_ERR
`endif
);

  logic                     sel;
  logic                     new_we;
  logic                     new_re;
  state_t                   state_q;
  state_t                   state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;
  logic [P_DATA_W-1:0]      hold_q;
  logic                     en_d;
  logic                     we_d;
  logic                     ld_addr;
  logic                     ld_din;
  logic                     cap_hold;
  logic [P_BRAM_ADDR_W-1:0] bram_offs;
`ifdef BRAM_BRIDGE_WP_EN
  logic                     wp_err_d;
`endif

  assign sel   = in_window(32'(I_ADDR), P_BASE, P_SIZE);
  assign O_SEL = sel;

  // Truncating before subtracting gives the same low bits as subtracting first
  assign bram_offs = P_BRAM_ADDR_W'(I_ADDR) - P_BRAM_ADDR_W'(P_BASE);

  bram_bridge_strobe_edge u_strobe_edge (
    .clk    (I_CLK),
    .reset  (I_RESET),
    .we_l   (I_WE_L),
    .re_l   (I_RE_L),
    .new_we (new_we),
    .new_re (new_re)
  );

  // The CPU waits only on a selected read that is not yet in hold. A concurrent
  // write strobe means the write won and no read is pending; reset drops the
  // stall in the same cycle as the abort.
  assign O_WAIT = sel & ~I_RE_L & I_WE_L & (state_q != RD_HOLD) & ~I_RESET;

  // The bus is driven from the hold register only for a selected read without a write
  assign IO_DATA = (sel && !I_RE_L && I_WE_L) ? hold_q : {P_DATA_W{1'bz}};

  // State register
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and access-control decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    en_d     = 1'b0;
    we_d     = 1'b0;
    ld_addr  = 1'b0;
    ld_din   = 1'b0;
    cap_hold = 1'b0;
`ifdef BRAM_BRIDGE_WP_EN
    wp_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sel && new_we) begin
          ld_addr = 1'b1;
          ld_din  = 1'b1;
          state_d = WR_DONE;
`ifdef BRAM_BRIDGE_WP_EN
          // A protected write still completes the handshake but never reaches the BRAM
          wp_err_d = I_WP;
          en_d     = ~I_WP;
          we_d     = ~I_WP;
`else
          en_d = 1'b1;
          we_d = 1'b1;
`endif
        end else if (sel && new_re) begin
          en_d    = 1'b1;
          ld_addr = 1'b1;
          cnt_d   = CNT_W'(P_RD_LAT);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          cap_hold = 1'b1;
          // If the CPU already gave up, skip the hold phase
          state_d  = I_RE_L ? IDLE : RD_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_HOLD: begin
        if (I_RE_L) state_d = IDLE;
      end
      WR_DONE: begin
        if (I_WE_L) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // BRAM port registers, read-latency counter and read hold register
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      O_BRAM_EN   <= 1'b0;
      O_BRAM_WE   <= 1'b0;
      O_BRAM_ADDR <= '0;
      O_BRAM_DIN  <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
    end else begin
      O_BRAM_EN <= en_d;
      O_BRAM_WE <= we_d;
      cnt_q     <= cnt_d;
      if (ld_addr)  O_BRAM_ADDR <= bram_offs;
      if (ld_din)   O_BRAM_DIN  <= IO_DATA;
      if (cap_hold) hold_q      <= I_BRAM_DOUT;
    end
  end

`ifdef BRAM_BRIDGE_WP_EN
  // One-cycle pulse flagging a blocked write
  always_ff @(posedge I_CLK) begin
    if (I_RESET) O_WP_ERR <= 1'b0;
    else         O_WP_ERR <= wp_err_d;
  end
`endif

endmodule

// File: tb/tb_bram_bus_bridge.sv
// Self-checking bench: three bridges (read latency 1, 2, 4) share one CPU strobe bus.
// Each has its own BRAM model and data bus; undriven buses float high through tri1.
// Expected values come from a window/offset rule and an associative-array memory model.
module tb_bram_bus_bridge;

  localparam int BASE = 'hC000;
  localparam int SIZE = 'h2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        we_l;
  logic        re_l;
  logic        wr_drive;
  logic [7:0]  wdat;
`ifdef BRAM_BRIDGE_WP_EN
  logic        wp;
  wire         wp_err_o [3];
`endif

  wire         en_o   [3];
  wire         we_o   [3];
  wire         wait_o [3];
  wire         sel_o  [3];
  wire [12:0]  addr_o [3];
  wire [7:0]   din_o  [3];
  wire [7:0]   dout_i [3];
  wire [7:0]   io_obs [3];

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_ref [int];
  int         keys [$];

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    tri1 [7:0]  io_bus;
    logic [7:0] mem  [0:8191];
    logic [7:0] pipe [0:3];

    assign io_bus    = wr_drive ? wdat : 8'bz;
    assign io_obs[k] = io_bus;
    assign dout_i[k] = pipe[L-1];

    // BRAM with L-cycle read latency; non-read cycles push garbage down the pipe
    always @(posedge clk) begin
      if (en_o[k] && we_o[k]) mem[addr_o[k]] <= din_o[k];
      pipe[0] <= (en_o[k] && !we_o[k]) ? mem[addr_o[k]] : 8'($urandom);
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    bram_bus_bridge #(.P_RD_LAT(L)) u_dut (
      .I_CLK       (clk),
      .I_RESET     (rst),
      .I_ADDR      (cpu_addr),
      .IO_DATA     (io_bus),
      .I_WE_L      (we_l),
      .I_RE_L      (re_l),
      .O_WAIT      (wait_o[k]),
      .O_SEL       (sel_o[k]),
      .O_BRAM_EN   (en_o[k]),
      .O_BRAM_WE   (we_o[k]),
      .O_BRAM_ADDR (addr_o[k]),
      .O_BRAM_DIN  (din_o[k]),
      .I_BRAM_DOUT (dout_i[k])
`ifdef BRAM_BRIDGE_WP_EN
      ,
      .I_WP        (wp),
      .O_WP_ERR    (wp_err_o[k])
`endif
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_addr = 16'h0000; we_l = 1'b1; re_l = 1'b1; wr_drive = 1'b0; wdat = 8'h00;
`ifdef BRAM_BRIDGE_WP_EN
    wp = 1'b0;
`endif
    step(); step();
    for (int k = 0; k < 3; k++) begin
      total++; if (en_o[k] !== 1'b0)     begin bad++; $display("FAIL reset_en inst%0d got=%b want=0", k, en_o[k]); end
      total++; if (we_o[k] !== 1'b0)     begin bad++; $display("FAIL reset_we inst%0d got=%b want=0", k, we_o[k]); end
      total++; if (addr_o[k] !== 13'h0)  begin bad++; $display("FAIL reset_addr inst%0d got=%h want=0", k, addr_o[k]); end
      total++; if (din_o[k] !== 8'h00)   begin bad++; $display("FAIL reset_din inst%0d got=%h want=0", k, din_o[k]); end
      total++; if (wait_o[k] !== 1'b0)   begin bad++; $display("FAIL reset_wait inst%0d got=%b want=0", k, wait_o[k]); end
      total++; if (sel_o[k] !== 1'b0)    begin bad++; $display("FAIL reset_sel inst%0d got=%b want=0", k, sel_o[k]); end
      total++; if (io_obs[k] !== 8'hFF)  begin bad++; $display("FAIL reset_bus inst%0d got=%h want=ff(undriven)", k, io_obs[k]); end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    bit         inwin;
    logic [12:0] off;
    int         en_n [3];
    int         we_n [3];
    int         wait_n [3];
    logic [12:0] a_cap [3];
    logic [7:0]  d_cap [3];
    inwin = (32'(a) >= BASE) && (32'(a) < BASE + SIZE);
    off   = 13'(32'(a) - BASE);
    for (int k = 0; k < 3; k++) begin en_n[k] = 0; we_n[k] = 0; wait_n[k] = 0; a_cap[k] = '0; d_cap[k] = '0; end
    cpu_addr = a; wdat = d; wr_drive = 1'b1; we_l = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (sel_o[k] !== inwin) begin bad++; $display("FAIL wr_sel inst%0d addr=%h got=%b want=%b", k, a, sel_o[k], inwin); end
    end
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 3; k++) if (wait_o[k]) wait_n[k]++;
      step();
      for (int k = 0; k < 3; k++) begin
        if (c == 0) begin
          total++;
          if (en_o[k] !== inwin) begin bad++; $display("FAIL wr_en_latency inst%0d got=%b want=%b", k, en_o[k], inwin); end
        end
        if (en_o[k]) begin
          en_n[k]++;
          if (we_o[k]) we_n[k]++;
          a_cap[k] = addr_o[k];
          d_cap[k] = din_o[k];
        end
      end
    end
    we_l = 1'b1; wr_drive = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      total++; if (en_n[k] != int'(inwin))  begin bad++; $display("FAIL wr_en_count inst%0d got=%0d want=%0d", k, en_n[k], inwin); end
      total++; if (we_n[k] != int'(inwin))  begin bad++; $display("FAIL wr_we_count inst%0d got=%0d want=%0d", k, we_n[k], inwin); end
      total++; if (wait_n[k] != 0)          begin bad++; $display("FAIL wr_wait inst%0d got=%0d want=0", k, wait_n[k]); end
      if (inwin) begin
        total++; if (a_cap[k] !== off) begin bad++; $display("FAIL wr_addr inst%0d got=%h want=%h", k, a_cap[k], off); end
        total++; if (d_cap[k] !== d)   begin bad++; $display("FAIL wr_data inst%0d got=%h want=%h", k, d_cap[k], d); end
      end
    end
    if (inwin) begin
      if (!mem_ref.exists(int'(off))) keys.push_back(int'(off));
      mem_ref[int'(off)] = d;
    end
  endtask

  task automatic do_read(input logic [15:0] a);
    bit          inwin;
    logic [12:0] off;
    logic [7:0]  exp;
    int          wait_n [3];
    int          en_n [3];
    bit          hold_err [3];
    inwin = (32'(a) >= BASE) && (32'(a) < BASE + SIZE);
    off   = 13'(32'(a) - BASE);
    exp   = (inwin && mem_ref.exists(int'(off))) ? mem_ref[int'(off)] : 8'hFF;
    for (int k = 0; k < 3; k++) begin wait_n[k] = 0; en_n[k] = 0; hold_err[k] = 1'b0; end
    cpu_addr = a; re_l = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (wait_o[k] !== inwin) begin bad++; $display("FAIL rd_wait_start inst%0d addr=%h got=%b want=%b", k, a, wait_o[k], inwin); end
    end
    for (int c = 0; c < 8; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        if (c == 0) begin
          total++;
          if (en_o[k] !== inwin || we_o[k] !== 1'b0) begin
            bad++; $display("FAIL rd_en_latency inst%0d got=%b/%b want=%b/0", k, en_o[k], we_o[k], inwin);
          end
          if (inwin) begin
            total++; if (addr_o[k] !== off) begin bad++; $display("FAIL rd_addr inst%0d got=%h want=%h", k, addr_o[k], off); end
          end
        end
        if (en_o[k]) en_n[k]++;
        if (wait_o[k]) wait_n[k]++;
        else if (io_obs[k] !== exp) hold_err[k] = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      total++; if (en_n[k] != int'(inwin)) begin bad++; $display("FAIL rd_en_count inst%0d got=%0d want=%0d", k, en_n[k], inwin); end
      total++;
      if (wait_n[k] != (inwin ? lat_of(k) + 1 : 0)) begin
        bad++; $display("FAIL rd_wait_len inst%0d got=%0d want=%0d", k, wait_n[k], inwin ? lat_of(k) + 1 : 0);
      end
      total++; if (hold_err[k] || io_obs[k] !== exp) begin bad++; $display("FAIL rd_data inst%0d got=%h want=%h", k, io_obs[k], exp); end
    end
    re_l = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (io_obs[k] !== 8'hFF) begin bad++; $display("FAIL rd_release_bus inst%0d got=%h want=ff(undriven)", k, io_obs[k]); end
    end
    step();
  endtask

  task automatic test_write_basic();
    do_write(16'hC010, 8'hA5);
  endtask

  task automatic test_read_basic();
    do_read(16'hC010);
  endtask

  task automatic test_addr_hold();
    logic [7:0]  exp;
    int          en_n [3];
    logic [12:0] a_cap [3];
    exp = mem_ref[int'(13'h0010)];
    for (int k = 0; k < 3; k++) begin en_n[k] = 0; a_cap[k] = '0; end
    cpu_addr = 16'hC010; re_l = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      for (int k = 0; k < 3; k++) if (en_o[k]) begin en_n[k]++; a_cap[k] = addr_o[k]; end
      cpu_addr = 16'(BASE + int'($urandom_range(0, SIZE - 1)));
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (en_n[k] != 1)         begin bad++; $display("FAIL hold_en_count inst%0d got=%0d want=1", k, en_n[k]); end
      total++; if (a_cap[k] !== 13'h010) begin bad++; $display("FAIL hold_addr inst%0d got=%h want=010", k, a_cap[k]); end
      total++; if (io_obs[k] !== exp)    begin bad++; $display("FAIL hold_data inst%0d got=%h want=%h", k, io_obs[k], exp); end
    end
    re_l = 1'b1;
    step();
  endtask

  task automatic test_window();
    do_read(16'hB000);
    do_write(16'hB000, 8'h5A);
    do_write(16'hC000, 8'h11);
    do_write(16'hDFFF, 8'h22);
    do_read(16'hE000);
    do_write(16'hE000, 8'h33);
    do_read(16'hDFFF);
    do_read(16'hBFFF);
  endtask

  task automatic test_both_strobes();
    logic [7:0] d;
    int en_n [3];
    int wait_n [3];
    d = 8'($urandom_range(0, 254));
    for (int k = 0; k < 3; k++) begin en_n[k] = 0; wait_n[k] = 0; end
    cpu_addr = 16'hC000; wdat = d; wr_drive = 1'b1; we_l = 1'b0; re_l = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      for (int k = 0; k < 3; k++) if (wait_o[k]) wait_n[k]++;
      step();
      for (int k = 0; k < 3; k++) begin
        if (en_o[k]) en_n[k]++;
        if (c == 0) begin
          total++;
          if (en_o[k] !== 1'b1 || we_o[k] !== 1'b1 || din_o[k] !== d) begin
            bad++; $display("FAIL both_write inst%0d got=%b/%b/%h want=1/1/%h", k, en_o[k], we_o[k], din_o[k], d);
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      total++; if (en_n[k] != 1)   begin bad++; $display("FAIL both_en_count inst%0d got=%0d want=1", k, en_n[k]); end
      total++; if (wait_n[k] != 0) begin bad++; $display("FAIL both_wait inst%0d got=%0d want=0", k, wait_n[k]); end
    end
    we_l = 1'b1; re_l = 1'b1; wr_drive = 1'b0;
    step();
    if (!mem_ref.exists(0)) keys.push_back(0);
    mem_ref[0] = d;
    do_read(16'hC000);
  endtask

  task automatic test_reset_mid();
    do_write(16'hC123, 8'h6E);
    cpu_addr = 16'hC123; re_l = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (wait_o[k] !== 1'b0) begin bad++; $display("FAIL rstmid_wait inst%0d got=%b want=0", k, wait_o[k]); end
    end
    step();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (en_o[k] !== 1'b0 || we_o[k] !== 1'b0 || addr_o[k] !== 13'h0 || din_o[k] !== 8'h0) begin
        bad++; $display("FAIL rstmid_regs inst%0d got=%b/%b/%h/%h want=0/0/0/0", k, en_o[k], we_o[k], addr_o[k], din_o[k]);
      end
    end
    step();
    rst = 1'b0;
    do_read(16'hC123);
  endtask

  task automatic test_back_to_back();
    do_write(16'hC200, 8'h01);
    do_read(16'hC200);
    do_write(16'hC201, 8'h02);
    do_write(16'hC200, 8'h03);
    do_read(16'hC201);
    do_read(16'hC200);
  endtask

`ifdef BRAM_BRIDGE_WP_EN
  task automatic test_write_protect();
    wp = 1'b1; cpu_addr = 16'hC010; wdat = 8'h3C; wr_drive = 1'b1; we_l = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (en_o[k] !== 1'b0 || we_o[k] !== 1'b0 || wp_err_o[k] !== 1'b1) begin
        bad++; $display("FAIL wp_block inst%0d got=%b/%b/%b want=0/0/1", k, en_o[k], we_o[k], wp_err_o[k]);
      end
    end
    step();
    for (int k = 0; k < 3; k++) begin
      total++; if (wp_err_o[k] !== 1'b0) begin bad++; $display("FAIL wp_pulse inst%0d got=%b want=0", k, wp_err_o[k]); end
    end
    we_l = 1'b1; wr_drive = 1'b0;
    step();
    wp = 1'b0;
    do_read(16'hC010);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int          r;
      logic [15:0] a;
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 'hBFFF));
        else                           a = 16'($urandom_range('hE000, 'hFFFF));
        if (r == 0) do_write(a, 8'($urandom_range(0, 254)));
        else        do_read(a);
      end else if (r < 6 || keys.size() == 0) begin
        a = 16'(BASE + int'($urandom_range(0, SIZE - 1)));
        do_write(a, 8'($urandom_range(0, 254)));
      end else begin
        a = 16'(BASE + keys[$urandom_range(0, keys.size() - 1)]);
        do_read(a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_addr_hold();
    test_window();
    test_both_strobes();
    test_reset_mid();
    test_back_to_back();
`ifdef BRAM_BRIDGE_WP_EN
    test_write_protect();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
